// File: rtl/reset_sequencer.sv
// Reset sequencer: once the clock source is locked, releases NUM_DOMAINS active-low resets,
// bit 0 first, STAGE_DELAY cycles apart. Define RESET_SEQ_LOCK_FILTER_EN to require LOCK_FILTER stable lock samples.
module reset_sequencer #(
    parameter int NUM_DOMAINS = 3,
    parameter int STAGE_DELAY = 16,
    parameter int SOFT_HOLD   = 4,
    parameter int LOCK_FILTER = 8
) (
    input  logic                   clk,
    input  logic                   rst_i,
    input  logic                   pll_locked,
    input  logic                   soft_rst_req,
    output logic [NUM_DOMAINS-1:0] rst_o,
    output logic                   done,
    output logic                   busy,
    output logic [1:0]             state_dbg
);

    localparam int                IDX_W      = $clog2(NUM_DOMAINS);
    localparam logic [7:0]        STAGE_LOAD = 8'(STAGE_DELAY - 1);
    localparam logic [7:0]        SOFT_LOAD  = 8'(SOFT_HOLD - 1);
    localparam logic [IDX_W-1:0]  LAST_IDX   = IDX_W'(NUM_DOMAINS - 1);

    if (NUM_DOMAINS < 2 || NUM_DOMAINS > 8 || STAGE_DELAY < 1 || STAGE_DELAY > 255 ||
        SOFT_HOLD < 1 || SOFT_HOLD > 255 || LOCK_FILTER < 2 || LOCK_FILTER > 255) begin : g_bad_cfg
        $error("reset_sequencer: parameter out of legal range");
    end

    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        DELAY     = 2'd1,
        RUN       = 2'd2,
        SOFT      = 2'd3
    } state_t;

    state_t           state;
    logic [7:0]       cnt;
    logic [IDX_W-1:0] idx;
    logic             lock_qual;

`ifdef RESET_SEQ_LOCK_FILTER_EN
    localparam logic [7:0] FILT_LAST = 8'(LOCK_FILTER - 1);
    logic [7:0] filt_cnt;

    // The sample that completes the run of LOCK_FILTER highs is itself the qualifying edge.
    assign lock_qual = pll_locked && (filt_cnt == FILT_LAST);

    always_ff @(posedge clk or negedge rst_i) begin
        if (!rst_i) begin
            filt_cnt <= '0;
        end else if (state != WAIT_LOCK || !pll_locked || lock_qual) begin
            filt_cnt <= '0;
        end else begin
            filt_cnt <= filt_cnt + 8'd1;
        end
    end
`else
    assign lock_qual = pll_locked;
`endif

    // Lock loss always looks at the raw pll_locked and outranks a soft request.
    always_ff @(posedge clk or negedge rst_i) begin
        if (!rst_i) begin
            state <= WAIT_LOCK;
            cnt   <= '0;
            idx   <= '0;
            rst_o <= '0;
            done  <= 1'b0;
            busy  <= 1'b0;
        end else begin
            case (state)
                WAIT_LOCK: begin
                    if (lock_qual) begin
                        state <= DELAY;
                        cnt   <= STAGE_LOAD;
                        idx   <= '0;
                        busy  <= 1'b1;
                    end
                end

                DELAY: begin
                    if (!pll_locked) begin
                        state <= WAIT_LOCK;
                        cnt   <= '0;
                        idx   <= '0;
                        rst_o <= '0;
                        done  <= 1'b0;
                        busy  <= 1'b0;
                    end else if (soft_rst_req) begin
                        state <= SOFT;
                        cnt   <= SOFT_LOAD;
                        idx   <= '0;
                        rst_o <= '0;
                        done  <= 1'b0;
                        busy  <= 1'b1;
                    end else if (cnt == 8'd0) begin
                        rst_o[idx] <= 1'b1;
                        if (idx == LAST_IDX) begin
                            state <= RUN;
                            done  <= 1'b1;
                            busy  <= 1'b0;
                        end else begin
                            idx <= idx + 1'b1;
                            cnt <= STAGE_LOAD;
                        end
                    end else begin
                        cnt <= cnt - 8'd1;
                    end
                end

                RUN: begin
                    if (!pll_locked) begin
                        state <= WAIT_LOCK;
                        cnt   <= '0;
                        idx   <= '0;
                        rst_o <= '0;
                        done  <= 1'b0;
                        busy  <= 1'b0;
                    end else if (soft_rst_req) begin
                        state <= SOFT;
                        cnt   <= SOFT_LOAD;
                        idx   <= '0;
                        rst_o <= '0;
                        done  <= 1'b0;
                        busy  <= 1'b1;
                    end
                end

                SOFT: begin
                    if (!pll_locked) begin
                        state <= WAIT_LOCK;
                        cnt   <= '0;
                        busy  <= 1'b0;
                    end else if (cnt == 8'd0) begin
                        state <= WAIT_LOCK;
                        busy  <= 1'b0;
                    end else begin
                        cnt <= cnt - 8'd1;
                    end
                end

                default: begin
                    state <= WAIT_LOCK;
                    cnt   <= '0;
                    idx   <= '0;
                    rst_o <= '0;
                    done  <= 1'b0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    // Debug view of the FSM: 0 WAIT_LOCK, 1 DELAY, 2 RUN, 3 SOFT.
    assign state_dbg = state;

endmodule

// File: tb/tb_reset_sequencer.sv
// Bench for reset_sequencer: a timeline model predicts {state, busy, done, rst_o} per cycle into a queue.
// Honours RESET_SEQ_LOCK_FILTER_EN the same way the design does.
module tb_reset_sequencer;

    localparam int N  = 3;
    localparam int SD = 16;
    localparam int SH = 4;
    localparam int LF = 8;
    localparam int W  = N + 4;
`ifdef RESET_SEQ_LOCK_FILTER_EN
    localparam int QUAL_STEPS = LF;
`else
    localparam int QUAL_STEPS = 1;
`endif

    logic         clk;
    logic         rst_i;
    logic         pll_locked;
    logic         soft_rst_req;
    logic [N-1:0] rst_o;
    logic         done;
    logic         busy;
    logic [1:0]   state_dbg;

    logic [W-1:0] exp_q[$];
    int           n_vec;
    int           n_err;

    // model: 0 WAIT_LOCK, 1 DELAY, 2 RUN, 3 SOFT; m_t counts cycles since entering the state
    int m_state;
    int m_t;
`ifdef RESET_SEQ_LOCK_FILTER_EN
    int m_filt;
`endif

    reset_sequencer #(
        .NUM_DOMAINS (N),
        .STAGE_DELAY (SD),
        .SOFT_HOLD   (SH),
        .LOCK_FILTER (LF)
    ) dut (
        .clk          (clk),
        .rst_i        (rst_i),
        .pll_locked   (pll_locked),
        .soft_rst_req (soft_rst_req),
        .rst_o        (rst_o),
        .done         (done),
        .busy         (busy),
        .state_dbg    (state_dbg)
    );

    // clock / watchdog
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, vectors=%0d", n_vec);
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic model_step(input logic rst, input logic pl, input logic sr);
        if (!rst) begin
            m_state = 0;
            m_t     = 0;
`ifdef RESET_SEQ_LOCK_FILTER_EN
            m_filt  = 0;
`endif
        end else begin
            case (m_state)
                0: begin
`ifdef RESET_SEQ_LOCK_FILTER_EN
                    if (!pl) m_filt = 0;
                    else if (m_filt == LF - 1) begin
                        m_filt  = 0;
                        m_state = 1;
                        m_t     = 0;
                    end else m_filt++;
`else
                    if (pl) begin
                        m_state = 1;
                        m_t     = 0;
                    end
`endif
                end
                1: begin
                    if (!pl) m_state = 0;
                    else if (sr) begin
                        m_state = 3;
                        m_t     = 0;
                    end else begin
                        m_t++;
                        if (m_t == N * SD) m_state = 2;
                    end
                end
                2: begin
                    if (!pl) m_state = 0;
                    else if (sr) begin
                        m_state = 3;
                        m_t     = 0;
                    end
                end
                default: begin
                    if (!pl) m_state = 0;
                    else begin
                        m_t++;
                        if (m_t == SH) m_state = 0;
                    end
                end
            endcase
        end
    endtask

    function automatic logic [W-1:0] model_out();
        logic [N-1:0] r;
        logic [1:0]   s;
        r = '0;
        s = 2'(m_state);
        if (m_state == 1) begin
            for (int k = 0; k < N; k++) if (m_t >= (k + 1) * SD) r[k] = 1'b1;
        end else if (m_state == 2) begin
            r = '1;
        end
        return {s, (m_state == 1 || m_state == 3), (m_state == 2), r};
    endfunction

    task automatic compare_out(input string tag);
        logic [W-1:0] e;
        if (exp_q.size() == 0) begin
            check({tag, "_qempty"}, 32'd0, 32'd1);
        end else begin
            e = exp_q.pop_front();
            check(tag, 32'({state_dbg, busy, done, rst_o}), 32'(e));
        end
    endtask

    // driver: inputs change on the falling edge, outputs sampled 1 ns after the rising edge
    task automatic step(input logic rst, input logic pl, input logic sr);
        @(negedge clk);
        rst_i        = rst;
        pll_locked   = pl;
        soft_rst_req = sr;
        model_step(rst, pl, sr);
        exp_q.push_back(model_out());
        @(posedge clk);
        #1;
        compare_out("cyc");
    endtask

    task automatic qualify();
        repeat (QUAL_STEPS) step(1'b1, 1'b1, 1'b0);
    endtask

    // call right after the qualifying step; measures release latencies from DELAY entry
    task automatic run_until_done(input string tag);
        int lat0;
        int latd;
        lat0 = -1;
        latd = -1;
        for (int i = 1; i <= 200 && latd < 0; i++) begin
            step(1'b1, 1'b1, 1'b0);
            if (lat0 < 0 && rst_o[0]) lat0 = i;
            if (done) latd = i;
        end
        check({tag, "_rst0_lat"}, 32'(lat0), 32'(SD));
        check({tag, "_done_lat"}, 32'(latd), 32'(N * SD));
    endtask

    initial begin
        int n_soft;
        n_vec        = 0;
        n_err        = 0;
        rst_i        = 1'b0;
        pll_locked   = 1'b0;
        soft_rst_req = 1'b0;
        model_step(1'b0, 1'b0, 1'b0);

        // reset held, then released with no lock
        repeat (3) step(1'b0, 1'b1, 1'b1);
        repeat (4) step(1'b1, 1'b0, 1'b0);

        // short lock pulse, drop, then stable lock
        repeat (5) step(1'b1, 1'b1, 1'b0);
        repeat (3) step(1'b1, 1'b0, 1'b0);
        qualify();
        run_until_done("boot");
        repeat (5) step(1'b1, 1'b1, 1'b0);

        // soft reset from RUN; a second request inside SOFT is ignored
        step(1'b1, 1'b1, 1'b1);
        n_soft = 0;
        for (int i = 0; i < 20; i++) begin
            if (state_dbg != 2'd3) break;
            n_soft++;
            step(1'b1, 1'b1, (i == 1));
        end
        check("soft_len", 32'(n_soft), 32'(SH));
        qualify();
        run_until_done("soft");

        // lock loss with rst_o = 011, then requalify
        step(1'b1, 1'b0, 1'b0);
        repeat (3) step(1'b1, 1'b0, 1'b0);
        qualify();
        repeat (40) step(1'b1, 1'b1, 1'b0);
        check("mid_seq_011", 32'(rst_o), 32'd3);
        step(1'b1, 1'b0, 1'b0);
        check("lockloss_clear", 32'(rst_o), 32'd0);
        repeat (5) step(1'b1, 1'b0, 1'b0);
        qualify();
        run_until_done("relock");

        // lock loss and soft request together; soft ignored in WAIT_LOCK
        step(1'b1, 1'b0, 1'b1);
        check("prio_busy", 32'(busy), 32'd0);
        repeat (3) step(1'b1, 1'b0, 1'b1);

        // soft request in DELAY, then lock loss inside SOFT
        qualify();
        repeat (20) step(1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b1);
        step(1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);

        // asynchronous reset between edges mid-DELAY
        qualify();
        repeat (25) step(1'b1, 1'b1, 1'b0);
        @(negedge clk);
        #2;
        rst_i = 1'b0;
        #1;
        model_step(1'b0, 1'b1, 1'b0);
        exp_q.push_back(model_out());
        compare_out("async_rst");
        repeat (3) step(1'b0, 1'b1, 1'b0);
        qualify();
        run_until_done("post_rst");

        // random traffic, mostly locked with occasional soft requests
        for (int i = 0; i < 400; i++) begin
            step(1'b1, ($urandom_range(0, 99) < 97), ($urandom_range(0, 99) < 3));
        end

        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/reset_sequencer.md
RESET_SEQUENCER -- requirements
Module: reset_sequencer

Interface
REQ-001 Parameter NUM_DOMAINS, default 3: number of sequenced reset outputs, legal range 2..8.
REQ-002 Parameter STAGE_DELAY, default 16: cycles between consecutive domain releases, legal range 1..255.
REQ-003 Parameter SOFT_HOLD, default 4: cycles all outputs stay asserted after a soft reset request, legal range 1..255.
REQ-004 Parameter LOCK_FILTER, default 8: consecutive high samples of pll_locked required when filtering is enabled, legal range 2..255.
REQ-005 clk  input  1  single clock for all logic.
REQ-006 rst_i  input  1  reset, asynchronous assertion, active-low; deassertion is synchronous to clk, driven by the upstream reset synchronizer.
REQ-007 pll_locked  input  1  clock-source lock indication, synchronous to clk.
REQ-008 soft_rst_req  input  1  single-cycle request to re-run the full reset sequence.
REQ-009 rst_o  output  NUM_DOMAINS  per-domain resets, active-low, bit 0 released first.
REQ-010 done  output  1  high when all domains are released and the block is in RUN.
REQ-011 busy  output  1  high in DELAY and SOFT states.

Function
REQ-012 The block SHALL implement exactly four states: WAIT_LOCK, DELAY, RUN and SOFT.
REQ-013 All outputs SHALL be registered, with no combinational path from any input to any output.
REQ-014 WAIT_LOCK: rst_o all 0, done 0, busy 0; a qualified lock at edge T SHALL enter DELAY with stage index 0 and the down-counter loaded with STAGE_DELAY-1.
REQ-015 DELAY: the counter SHALL decrement each cycle; at the edge where it reaches 0, rst_o[index] SHALL go 1 and the counter SHALL reload.
REQ-016 Timing: rst_o[k] SHALL rise at edge T+(k+1)*STAGE_DELAY; released bits SHALL stay 1 until a reset event.
REQ-017 On the edge releasing rst_o[NUM_DOMAINS-1], the state SHALL become RUN and done SHALL go 1 on that same edge.
REQ-018 Lock loss: pll_locked (unfiltered) sampled 0 in DELAY, RUN or SOFT SHALL drive all rst_o to 0, done to 0 and the state to WAIT_LOCK on the next edge.
REQ-019 Soft reset: soft_rst_req sampled 1 in DELAY or RUN SHALL drive all rst_o to 0, done to 0 and the state to SOFT on the next edge, with the counter loaded with SOFT_HOLD-1.
REQ-020 SOFT: once the counter reaches 0, the state SHALL become WAIT_LOCK; total time in SOFT is SOFT_HOLD cycles.
REQ-021 soft_rst_req SHALL be ignored in WAIT_LOCK and SOFT.
REQ-022 When lock loss and soft_rst_req occur in the same cycle, lock loss SHALL take priority.
REQ-023 The counter width SHALL be 8 bits; the stage index width SHALL be ceil(log2(NUM_DOMAINS)), and the index SHALL never exceed NUM_DOMAINS-1.

Reset
REQ-024 rst_i low SHALL immediately and asynchronously force rst_o all 0, done 0, busy 0, state WAIT_LOCK, and counter, index and lock filter to 0, including mid-sequence.
REQ-025 After rst_i rises, the first state change SHALL occur no earlier than the following clk edge.

Configuration
REQ-026 Macro RESET_SEQ_LOCK_FILTER_EN defined: a qualified lock requires pll_locked sampled 1 on LOCK_FILTER consecutive edges, and any 0 sample clears the filter count.
REQ-027 Macro RESET_SEQ_LOCK_FILTER_EN undefined: a qualified lock is a single sample of pll_locked = 1; the filter counter SHALL NOT exist.
REQ-028 With or without the macro, lock loss (REQ-018) SHALL always use the unfiltered input.

Verification
REQ-029 Defaults, filter off, pll_locked held 1 and rising from edge 10 -> rst_o = 001 @26, 011 @42, 111 @58, and done = 1 @58.
REQ-030 Filter on, pll_locked pulses high for 5 cycles, then stays high from edge 20 -> no DELAY entry until edge 27, and rst_o[0] rises @43.
REQ-031 soft_rst_req at edge 70 while in RUN -> rst_o = 000 and done = 0 @71, busy high in SOFT for 4 cycles, then the sequence restarts and rst_o[0] rises 16 cycles after WAIT_LOCK exit.
REQ-032 pll_locked drops while rst_o = 011 -> rst_o = 000 on the next edge, state WAIT_LOCK, and the released bits do not re-rise until lock is requalified.
REQ-033 soft_rst_req and pll_locked = 0 sampled on the same edge -> WAIT_LOCK entered, not SOFT; busy stays 0.
REQ-034 rst_i pulled low asynchronously mid-DELAY (between edges) -> rst_o = 000 and done = 0 without waiting for a clk edge, then the full sequence reruns after release.
